// File: rtl/hazard_forward_unit_pkg.sv
// Shared encodings for the hazard/forwarding controller.
// Combinational helpers only; no state.
// No flow control: constants and a forwarding-select helper.
package hazard_forward_unit_pkg;

    // Operand source selection for a forwarded value
    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_M    = 2'd1,
        FWD_W    = 2'd2
    } fwd_sel_e;

    // Mult/div scoreboard states
    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // Hard-wired zero register index
    localparam int REG0 = 0;

    // M-stage match wins over W-stage match
    function automatic fwd_sel_e fwd_select(input logic m_hit, input logic w_hit);
        if (m_hit)      return FWD_M;
        else if (w_hit) return FWD_W;
        else            return FWD_NONE;
    endfunction

endpackage

// File: rtl/hazard_forward_unit_md_scoreboard.sv
// Tracks one in-flight mult/div: pending flag, destination, latency counter.
// done pulses MD_LATENCY cycles after start; start ignored while busy.
// No backpressure: caller must only start when not pending.
module md_scoreboard
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_BITS   = 5,
    parameter int MD_LATENCY = 8
) (
    input  logic                clock_i,
    input  logic                reset_i,     // active-low, synchronous
    input  logic                start_i,
    input  logic [REG_BITS-1:0] start_rd_i,
    output logic                pending_o,
    output logic                done_o,
    output logic [REG_BITS-1:0] rd_o
);

    localparam int CNT_BITS = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;

    md_state_e             state_q, state_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic [REG_BITS-1:0]   rd_q, rd_d;

    // State, counter and destination registers; reset abandons any op
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
        end
    end

    // Next state: load on start, count down while busy, finish at zero
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        done_o  = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (start_i) begin
                    state_d = MD_BUSY;
                    cnt_d   = CNT_BITS'(MD_LATENCY - 1);
                    rd_d    = start_rd_i;
                end
            end
            MD_BUSY: begin
                if (cnt_q == '0) begin
                    done_o  = 1'b1;
                    state_d = MD_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_BITS'(1);
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    assign pending_o = (state_q == MD_BUSY);
    assign rd_o      = rd_q;

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand forwarding, load-use interlock and mult/div dependency stalls.
// Forwarding and stall are combinational (zero latency); md status registered.
// stall holds PC/F-D and bubble_dx inserts a NOP into D/X in the same cycle.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int REG_BITS   = 5,
    parameter int MD_LATENCY = 8
) (
    input  logic                clock_i,
    input  logic                reset_i,     // active-low, synchronous
    input  logic [REG_BITS-1:0] d_rs_i,
    input  logic [REG_BITS-1:0] d_rt_i,
    input  logic [REG_BITS-1:0] d_rd_i,
    input  logic                d_uses_rs_i,
    input  logic                d_uses_rt_i,
    input  logic                d_we_i,
    input  logic                d_is_md_i,
    input  logic [REG_BITS-1:0] x_rs_i,
    input  logic [REG_BITS-1:0] x_rt_i,
    input  logic [REG_BITS-1:0] x_rd_i,
    input  logic                x_valid_i,
    input  logic                x_we_i,
    input  logic                x_is_load_i,
    input  logic                x_is_md_i,
    input  logic [WIDTH-1:0]    x_a_i,
    input  logic [WIDTH-1:0]    x_b_i,
    input  logic [REG_BITS-1:0] m_rd_i,
    input  logic                m_we_i,
    input  logic [WIDTH-1:0]    m_o_i,
    input  logic [WIDTH-1:0]    m_b_i,
    input  logic [REG_BITS-1:0] w_rd_i,
    input  logic                w_we_i,
    input  logic [WIDTH-1:0]    w_data_i,
    output logic [WIDTH-1:0]    x_a_fwd_o,
    output logic [WIDTH-1:0]    x_b_fwd_o,
    output logic [WIDTH-1:0]    m_b_fwd_o,
    output logic                stall_o,
    output logic                bubble_dx_o,
    output logic                md_start_o,
    output logic                md_busy_o,
    output logic                md_done_o,
    output logic [REG_BITS-1:0] md_rd_o
);

    localparam logic [REG_BITS-1:0] ZERO_IDX = REG_BITS'(REG0);

    logic                md_pending;
    logic [REG_BITS-1:0] md_rd;
    fwd_sel_e            sel_a, sel_b;
    logic                load_use, md_stall, md_raw, md_waw;

    // x_we is carried for completeness; the X-stage result is not forwarded here
    logic unused_x_we;
    assign unused_x_we = x_we_i;

    // Operand source selection; M has priority, register 0 never forwards
    always_comb begin
        sel_a = fwd_select(m_we_i && (m_rd_i == x_rs_i) && (x_rs_i != ZERO_IDX),
                           w_we_i && (w_rd_i == x_rs_i) && (x_rs_i != ZERO_IDX));
        sel_b = fwd_select(m_we_i && (m_rd_i == x_rt_i) && (x_rt_i != ZERO_IDX),
                           w_we_i && (w_rd_i == x_rt_i) && (x_rt_i != ZERO_IDX));
    end

    // Operand and store-data muxes
    always_comb begin
        case (sel_a)
            FWD_M:   x_a_fwd_o = m_o_i;
            FWD_W:   x_a_fwd_o = w_data_i;
            default: x_a_fwd_o = x_a_i;
        endcase
        case (sel_b)
            FWD_M:   x_b_fwd_o = m_o_i;
            FWD_W:   x_b_fwd_o = w_data_i;
            default: x_b_fwd_o = x_b_i;
        endcase
        // Store data register index arrives on the M-stage rd field
        m_b_fwd_o = (w_we_i && (w_rd_i == m_rd_i) && (m_rd_i != ZERO_IDX)) ? w_data_i : m_b_i;
    end

    // Interlocks: load-use against X, dependency/structural against in-flight md
    always_comb begin
        load_use = x_valid_i && x_is_load_i && (x_rd_i != ZERO_IDX) &&
                   ((d_uses_rs_i && (d_rs_i == x_rd_i)) ||
                    (d_uses_rt_i && (d_rt_i == x_rd_i)));
        md_raw   = (d_uses_rs_i && (d_rs_i == md_rd)) ||
                   (d_uses_rt_i && (d_rt_i == md_rd));
        md_waw   = d_we_i && (d_rd_i == md_rd);
        // A zero destination still occupies the unit but carries no data hazard
        md_stall = md_pending && (d_is_md_i || ((md_rd != ZERO_IDX) && (md_raw || md_waw)));
    end

    assign stall_o     = load_use || md_stall;
    assign bubble_dx_o = stall_o;
    assign md_start_o  = x_valid_i && x_is_md_i && !md_pending;
    assign md_busy_o   = md_pending;
    assign md_rd_o     = md_rd;

    md_scoreboard #(
        .REG_BITS   (REG_BITS),
        .MD_LATENCY (MD_LATENCY)
    ) u_md_scoreboard (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .start_i    (md_start_o),
        .start_rd_i (x_rd_i),
        .pending_o  (md_pending),
        .done_o     (md_done_o),
        .rd_o       (md_rd)
    );

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench with a cycle-indexed reference model and per-cycle compare.
module tb_hazard_forward_unit;
    localparam int W  = 32;
    localparam int RB = 5;
    localparam int L  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [RB-1:0] d_rs, d_rt, d_rd, x_rs, x_rt, x_rd, m_rd, w_rd;
    logic          d_uses_rs, d_uses_rt, d_we, d_is_md;
    logic          x_valid, x_we, x_is_load, x_is_md, m_we, w_we;
    logic [W-1:0]  x_a, x_b, m_o, m_b, w_data;
    logic [W-1:0]  x_a_fwd, x_b_fwd, m_b_fwd;
    logic          stall, bubble_dx, md_start, md_busy, md_done;
    logic [RB-1:0] md_rd;

    hazard_forward_unit #(.WIDTH(W), .REG_BITS(RB), .MD_LATENCY(L)) dut (
        .clock_i(clk), .reset_i(rst_n),
        .d_rs_i(d_rs), .d_rt_i(d_rt), .d_rd_i(d_rd),
        .d_uses_rs_i(d_uses_rs), .d_uses_rt_i(d_uses_rt), .d_we_i(d_we), .d_is_md_i(d_is_md),
        .x_rs_i(x_rs), .x_rt_i(x_rt), .x_rd_i(x_rd),
        .x_valid_i(x_valid), .x_we_i(x_we), .x_is_load_i(x_is_load), .x_is_md_i(x_is_md),
        .x_a_i(x_a), .x_b_i(x_b),
        .m_rd_i(m_rd), .m_we_i(m_we), .m_o_i(m_o), .m_b_i(m_b),
        .w_rd_i(w_rd), .w_we_i(w_we), .w_data_i(w_data),
        .x_a_fwd_o(x_a_fwd), .x_b_fwd_o(x_b_fwd), .m_b_fwd_o(m_b_fwd),
        .stall_o(stall), .bubble_dx_o(bubble_dx),
        .md_start_o(md_start), .md_busy_o(md_busy), .md_done_o(md_done), .md_rd_o(md_rd)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the in-flight op is remembered by its issue cycle
    int            cyc = 0;
    bit            check_en = 0;
    bit            mdl_act = 0;
    int            mdl_iss = 0;
    logic [RB-1:0] mdl_rd = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            mdl_act = 0;
            mdl_rd  = '0;
        end else if (mdl_act && cyc == mdl_iss + L) begin
            mdl_act = 0;
        end else if (!mdl_act && x_valid && x_is_md) begin
            mdl_act = 1;
            mdl_iss = cyc;
            mdl_rd  = x_rd;
        end
        cyc++;
    end

    function automatic logic [W-1:0] fwd(input logic [RB-1:0] src, input logic [W-1:0] latched);
        if (m_we && m_rd == src && src != 0) return m_o;
        if (w_we && w_rd == src && src != 0) return w_data;
        return latched;
    endfunction

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        if (check_en) begin
            logic lu, ms, st, dn;
            lu = x_valid && x_is_load && x_rd != 0 &&
                 ((d_uses_rs && d_rs == x_rd) || (d_uses_rt && d_rt == x_rd));
            ms = mdl_act && (d_is_md || (mdl_rd != 0 &&
                 ((d_uses_rs && d_rs == mdl_rd) || (d_uses_rt && d_rt == mdl_rd) ||
                  (d_we && d_rd == mdl_rd))));
            st = lu || ms;
            dn = mdl_act && (cyc == mdl_iss + L);
            chk("cyc_x_a_fwd", x_a_fwd, fwd(x_rs, x_a));
            chk("cyc_x_b_fwd", x_b_fwd, fwd(x_rt, x_b));
            chk("cyc_m_b_fwd", m_b_fwd, (w_we && w_rd == m_rd && m_rd != 0) ? w_data : m_b);
            chk("cyc_stall", {31'd0, stall}, {31'd0, st});
            chk("cyc_bubble", {31'd0, bubble_dx}, {31'd0, st});
            chk("cyc_md_start", {31'd0, md_start}, {31'd0, x_valid && x_is_md && !mdl_act});
            chk("cyc_md_busy", {31'd0, md_busy}, {31'd0, mdl_act});
            chk("cyc_md_done", {31'd0, md_done}, {31'd0, dn});
            chk("cyc_md_rd", {27'd0, md_rd}, {27'd0, mdl_rd});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        {d_rs, d_rt, d_rd, x_rs, x_rt, x_rd, m_rd, w_rd} = '0;
        {d_uses_rs, d_uses_rt, d_we, d_is_md} = '0;
        {x_valid, x_we, x_is_load, x_is_md, m_we, w_we} = '0;
        x_a = 32'hA0A0_0001; x_b = 32'hB0B0_0002;
        m_o = '0; m_b = '0; w_data = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        clr();
        step(); step();
        check_en = 1;
        #1;
        chk("rst_busy", {31'd0, md_busy}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_md_rd", {27'd0, md_rd}, 32'd0);
        step();
        rst_n = 1'b1;

        // Forwarding: M beats W, both operands
        step(); clr();
        m_we = 1; m_rd = 3; m_o = 32'h11; w_we = 1; w_rd = 3; w_data = 32'h22;
        x_rs = 3; x_rt = 3; #1;
        chk("fwd_m_a", x_a_fwd, 32'h11);
        chk("fwd_m_b", x_b_fwd, 32'h11);
        step(); m_we = 0; #1;
        chk("fwd_w_a", x_a_fwd, 32'h22);
        step(); m_we = 1; m_rd = 4; x_rt = 4; #1;
        chk("fwd_mix_a", x_a_fwd, 32'h22);
        chk("fwd_mix_b", x_b_fwd, 32'h11);

        // Register zero never forwards
        step(); clr();
        w_we = 1; w_rd = 0; w_data = 32'hFFFF; m_we = 1; m_rd = 0; m_o = 32'h99;
        x_rs = 0; x_rt = 0; x_a = 32'h1234; #1;
        chk("fwd_r0_a", x_a_fwd, 32'h1234);
        chk("fwd_r0_b", x_b_fwd, 32'hB0B0_0002);

        // Store data
        step(); clr();
        m_rd = 6; m_b = 32'h5555; w_we = 1; w_rd = 6; w_data = 32'h6666; #1;
        chk("st_fwd", m_b_fwd, 32'h6666);
        step(); m_rd = 0; w_rd = 0; #1;
        chk("st_r0", m_b_fwd, 32'h5555);

        // Load-use
        step(); clr();
        x_valid = 1; x_is_load = 1; x_we = 1; x_rd = 5; d_uses_rs = 1; d_rs = 5; #1;
        chk("lu_stall", {31'd0, stall}, 32'd1);
        chk("lu_bubble", {31'd0, bubble_dx}, 32'd1);
        step(); clr();
        x_rs = 5; w_we = 1; w_rd = 5; w_data = 32'h77; #1;
        chk("lu_rel_stall", {31'd0, stall}, 32'd0);
        chk("lu_w_fwd", x_a_fwd, 32'h77);
        step(); clr();
        x_valid = 1; x_is_load = 1; x_rd = 0; d_uses_rs = 1; d_rs = 0; #1;
        chk("lu_r0", {31'd0, stall}, 32'd0);
        step(); x_rd = 5; d_rs = 5; d_uses_rs = 0; #1;
        chk("lu_unused", {31'd0, stall}, 32'd0);

        // mul r7: RAW stall T+1..T+8, done at T+8, release T+9
        step(); clr();
        x_valid = 1; x_is_md = 1; x_we = 1; x_rd = 7; #1;
        chk("mul_start", {31'd0, md_start}, 32'd1);
        for (int i = 1; i <= L; i++) begin
            step(); clr();
            d_uses_rs = 1; d_rs = 7;
            if (i == 3) begin d_uses_rs = 0; d_we = 1; d_rd = 7; end
            if (i == 5) begin x_valid = 1; x_is_load = 1; x_rd = 7; end
            #1;
            chk("mul_stall", {31'd0, stall}, 32'd1);
            chk("mul_busy", {31'd0, md_busy}, 32'd1);
            chk("mul_done", {31'd0, md_done}, (i == L) ? 32'd1 : 32'd0);
            chk("mul_rd", {27'd0, md_rd}, 32'd7);
        end
        step(); clr(); d_uses_rs = 1; d_rs = 7; #1;
        chk("mul_release", {31'd0, stall}, 32'd0);
        chk("mul_idle", {31'd0, md_busy}, 32'd0);

        // Structural: div behind mul
        step(); clr();
        x_valid = 1; x_is_md = 1; x_rd = 8; #1;
        chk("mul2_start", {31'd0, md_start}, 32'd1);
        for (int i = 1; i <= L; i++) begin
            step(); clr(); d_is_md = 1; d_rd = 9; #1;
            chk("struct_stall", {31'd0, stall}, 32'd1);
        end
        step(); clr(); x_valid = 1; x_is_md = 1; x_rd = 9; #1;
        chk("div_start", {31'd0, md_start}, 32'd1);
        chk("div_nostall", {31'd0, stall}, 32'd0);
        step(); clr(); #1;
        chk("div_rd", {27'd0, md_rd}, 32'd9);

        // Reset during the div at T+4
        step(); step(); clr(); d_uses_rs = 1; d_rs = 9;
        rst_n = 1'b0;
        step(); rst_n = 1'b1; #1;
        chk("rst_mid_busy", {31'd0, md_busy}, 32'd0);
        chk("rst_mid_stall", {31'd0, stall}, 32'd0);
        for (int i = 0; i < L + 2; i++) begin
            step(); #1;
            chk("rst_no_done", {31'd0, md_done}, 32'd0);
        end

        // Zero destination: occupies unit, no data stall
        step(); clr(); x_valid = 1; x_is_md = 1; x_rd = 0;
        step(); clr(); d_uses_rs = 1; d_rs = 0; d_we = 1; d_rd = 0; #1;
        chk("md_r0_nostall", {31'd0, stall}, 32'd0);
        step(); clr(); d_is_md = 1; #1;
        chk("md_r0_struct", {31'd0, stall}, 32'd1);
        for (int i = 0; i < L; i++) begin
            step(); clr();
        end
        step();
        check_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
